// File: rtl/shift_exec_stage.sv
// Two-stage handshaked 32-bit shift unit (SLL/SRL/SRA/ROL): S1 captures operands, S2 holds the result.
// Optional Carry output (last bit shifted out) is built when SHIFT_EXEC_CARRY_EN is defined.
module shift_exec_stage #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [SHW-1:0]   in2,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy
`ifdef SHIFT_EXEC_CARRY_EN
  ,
  output logic             carry
`endif
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } shift_op_e;

  // Stage 1: captured operands
  logic             s1_valid_reg;
  logic             s1_valid_next;
  logic [WIDTH-1:0] s1_data_reg;
  logic [SHW-1:0]   s1_amt_reg;
  shift_op_e        s1_op_reg;

  // Stage 2: registered result
  logic             s2_valid_reg;
  logic             s2_valid_next;
  logic [WIDTH-1:0] s2_result_reg;
  logic             s2_zero_reg;

  logic             s2_load;
  logic             in_fire;
  logic             out_fire;

  logic             is_right;
  logic             is_rotate;
  logic             fill_bit;
  logic [WIDTH-1:0] left_in;
  logic [WIDTH-1:0] left_out;
  logic [WIDTH-1:0] shift_result;

  assign s2_load  = s1_valid_reg & (~s2_valid_reg | out_ready);
  assign in_ready = ~s1_valid_reg | s2_load;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = s2_valid_reg & out_ready;

  // Right shifts reuse the left shifter by bit-reversing the operand and the result.
  assign is_right  = (s1_op_reg == OP_SRL) || (s1_op_reg == OP_SRA);
  assign is_rotate = (s1_op_reg == OP_ROL);
  assign fill_bit  = (s1_op_reg == OP_SRA) & s1_data_reg[WIDTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign left_in[gi]      = is_right ? s1_data_reg[WIDTH-1-gi] : s1_data_reg[gi];
      assign shift_result[gi] = is_right ? left_out[WIDTH-1-gi]    : left_out[gi];
    end
  endgenerate

  // Log-depth barrel: stage k moves by 2**k, filling from the wrap (ROL) or the fill bit.
  always_comb begin
    left_out = left_in;
    for (int k = 0; k < SHW; k++) begin
      if (s1_amt_reg[k]) begin
        if (is_rotate) begin
          left_out = (left_out << (1 << k)) | (left_out >> (WIDTH - (1 << k)));
        end else if (fill_bit) begin
          left_out = (left_out << (1 << k)) | ~({WIDTH{1'b1}} << (1 << k));
        end else begin
          left_out = left_out << (1 << k);
        end
      end
    end
  end

`ifdef SHIFT_EXEC_CARRY_EN
  localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);

  logic [SHW:0] carry_idx;
  logic         shift_carry;
  logic         s2_carry_reg;

  // In the left-shift domain the last bit out is always left_in[WIDTH-n].
  assign carry_idx   = WIDTH_W - {1'b0, s1_amt_reg};
  assign shift_carry = (s1_amt_reg == '0) ? 1'b0 :
                       is_rotate          ? shift_result[0] :
                                            left_in[carry_idx[SHW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_carry_reg <= 1'b0;
    end else if (s2_load && !flush) begin
      s2_carry_reg <= shift_carry;
    end
  end

  assign carry = s2_carry_reg;
`endif

  always_comb begin
    s1_valid_next = s1_valid_reg;
    if (flush) begin
      s1_valid_next = 1'b0;
    end else if (in_fire) begin
      s1_valid_next = 1'b1;
    end else if (s2_load) begin
      s1_valid_next = 1'b0;
    end
  end

  always_comb begin
    s2_valid_next = s2_valid_reg;
    if (flush) begin
      s2_valid_next = 1'b0;
    end else if (s2_load) begin
      s2_valid_next = 1'b1;
    end else if (out_fire) begin
      s2_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_data_reg   <= '0;
      s1_amt_reg    <= '0;
      s1_op_reg     <= OP_SLL;
      s2_valid_reg  <= 1'b0;
      s2_result_reg <= '0;
      s2_zero_reg   <= 1'b1;
    end else begin
      s1_valid_reg <= s1_valid_next;
      s2_valid_reg <= s2_valid_next;
      // A flush kills the valids but leaves the data registers untouched.
      if (in_fire && !flush) begin
        s1_data_reg <= in1;
        s1_amt_reg  <= in2;
        s1_op_reg   <= shift_op_e'(op);
      end
      if (s2_load && !flush) begin
        s2_result_reg <= shift_result;
        s2_zero_reg   <= (shift_result == '0);
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign out       = s2_result_reg;
  assign zero      = s2_zero_reg;
  assign busy      = s1_valid_reg | s2_valid_reg;

  // A stalled result must not change until it is taken.
  hold_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out) && $stable(zero)));

endmodule

// File: tb/tb_shift_exec_stage.sv
// Scoreboard bench for shift_exec_stage: driver pushes expected results, monitor pops on output transfer.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in1 = '0;
  logic [4:0]  in2 = '0;
  logic [1:0]  op = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out;
  logic        zero;
  logic        busy;
`ifdef SHIFT_EXEC_CARRY_EN
  logic        carry;
`endif

  shift_exec_stage #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .busy(busy)
`ifdef SHIFT_EXEC_CARRY_EN
    , .carry(carry)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] out;
    logic        zero;
    logic        carry;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  n;
    logic [1:0]  o;
    logic [31:0] r;
    logic        c;
  } vec_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        s_in_ready, s_out_valid, s_busy;
  bit          mon_hold = 1'b0;
  logic [31:0] mon_out;
  logic        mon_zero;
  exp_t        none = '{default: '0};

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model straight from the operation definitions.
  function automatic logic [31:0] m_shift(logic [31:0] a, int n, logic [1:0] o);
    case (o)
      2'b00:   return a << n;
      2'b01:   return a >> n;
      2'b10:   return 32'($signed(a) >>> n);
      default: return (n == 0) ? a : ((a << n) | (a >> (32 - n)));
    endcase
  endfunction

  function automatic logic m_carry(logic [31:0] a, int n, logic [1:0] o);
    logic [31:0] r;
    if (n == 0) return 1'b0;
    r = m_shift(a, n, o);
    case (o)
      2'b00:   return a[32-n];
      2'b11:   return r[0];
      default: return a[n-1];
    endcase
  endfunction

  // Monitor: samples just before each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        if (mon_hold) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          if (out_valid) begin
            chk("hold_out", out, mon_out);
            chk("hold_zero", 32'(zero), 32'(mon_zero));
          end
        end
        mon_hold = out_valid && !out_ready && !flush;
        mon_out  = out;
        mon_zero = zero;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got 0x%08h required no output at %0t", out, $time);
          end else begin
            e = sb.pop_front();
            $display("result out=0x%08h zero=%0b expected 0x%08h", out, zero, e.out);
            chk("out", out, e.out);
            chk("zero", 32'(zero), 32'(e.zero));
`ifdef SHIFT_EXEC_CARRY_EN
            chk("carry", 32'(carry), 32'(e.carry));
`endif
          end
        end
      end else begin
        mon_hold = 1'b0;
      end
    end
  end

  task automatic step(input bit v, input logic [31:0] a, input logic [4:0] n, input logic [1:0] o,
                      input bit ordy, input bit fl, input bit use_exp, input exp_t ex, output bit acc);
    exp_t e;
    @(negedge clk);
    #1;
    in_valid = v; in1 = a; in2 = n; op = o; out_ready = ordy; flush = fl;
    #3;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_busy      = busy;
    acc = v && in_ready && !fl;
    if (acc) begin
      if (use_exp) begin
        e = ex;
      end else begin
        e.out   = m_shift(a, int'(n), o);
        e.zero  = (e.out == 32'd0);
        e.carry = m_carry(a, int'(n), o);
      end
      sb.push_back(e);
      $display("issue in1=0x%08h n=%0d op=%0d expect 0x%08h", a, n, o, e.out);
    end
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    flush = 1'b0;
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    step(1'b0, 32'd0, 5'd0, 2'd0, ordy, 1'b0, 1'b0, none, acc);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out"}, out, 32'd0);
    chk({tag, "_zero"}, 32'(zero), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
`ifdef SHIFT_EXEC_CARRY_EN
    chk({tag, "_carry"}, 32'(carry), 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [0:10];
    exp_t ex;
    bit   acc;
    logic [31:0] a;
    int   nv;

    vecs = '{
      '{32'hF000_0000, 5'd4,  2'b10, 32'hFF00_0000, 1'b0},
      '{32'hF000_0000, 5'd4,  2'b01, 32'h0F00_0000, 1'b0},
      '{32'h8000_0001, 5'd4,  2'b11, 32'h0000_0018, 1'b0},
      '{32'h0000_0001, 5'd1,  2'b01, 32'h0000_0000, 1'b1},
      '{32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, 1'b0},
      '{32'h9ABC_DEF0, 5'd0,  2'b10, 32'h9ABC_DEF0, 1'b0},
      '{32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF, 1'b0},
      '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0},
      '{32'h0000_0003, 5'd31, 2'b00, 32'h8000_0000, 1'b1},
      '{32'h0000_0001, 5'd31, 2'b11, 32'h8000_0000, 1'b0},
      '{32'hC000_0000, 5'd31, 2'b01, 32'h0000_0001, 1'b1}
    };
    nv = 11;

    // Reset values while held in reset.
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single SLL request and its two-edge latency.
    ex = '{out: 32'h0000_0002, zero: 1'b0, carry: 1'b1};
    step(1'b1, 32'h8000_0001, 5'd1, 2'b00, 1'b1, 1'b0, 1'b1, ex, acc);
    chk("t1_accept", 32'(acc), 32'd1);
    idle(1'b1);
    chk("t1_valid_n1", 32'(s_out_valid), 32'd0);
    idle(1'b1);
    chk("t1_valid_n2", 32'(s_out_valid), 32'd1);
    idle(1'b1);

    // Directed vectors issued back-to-back: full throughput, no bubbles.
    for (int c = 0; c < nv + 3; c++) begin
      if (c < nv) begin
        ex = '{out: vecs[c].r, zero: (vecs[c].r == 32'd0), carry: vecs[c].c};
        step(1'b1, vecs[c].a, vecs[c].n, vecs[c].o, 1'b1, 1'b0, 1'b1, ex, acc);
        chk("t3_in_ready", 32'(s_in_ready), 32'd1);
      end else begin
        idle(1'b1);
      end
      chk("t3_out_valid", 32'(s_out_valid), 32'((c >= 2) && (c <= nv + 1)));
    end

    // Backpressure: two held, third stalls until S2 advances.
    step(1'b1, $urandom, 5'(2), 2'b00, 1'b0, 1'b0, 1'b0, none, acc);
    chk("t4_acc0", 32'(acc), 32'd1);
    step(1'b1, $urandom, 5'(7), 2'b10, 1'b0, 1'b0, 1'b0, none, acc);
    chk("t4_acc1", 32'(acc), 32'd1);
    a = $urandom;
    step(1'b1, a, 5'(13), 2'b11, 1'b0, 1'b0, 1'b0, none, acc);
    chk("t4_acc2_blocked", 32'(acc), 32'd0);
    chk("t4_in_ready", 32'(s_in_ready), 32'd0);
    chk("t4_busy", 32'(s_busy), 32'd1);
    step(1'b1, a, 5'(13), 2'b11, 1'b0, 1'b0, 1'b0, none, acc);
    chk("t4_acc2_still_blocked", 32'(acc), 32'd0);
    step(1'b1, a, 5'(13), 2'b11, 1'b1, 1'b0, 1'b0, none, acc);
    chk("t4_acc2_on_advance", 32'(acc), 32'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Flush with both stages full and a pending request.
    step(1'b1, $urandom, 5'(3), 2'b01, 1'b0, 1'b0, 1'b0, none, acc);
    step(1'b1, $urandom, 5'(9), 2'b00, 1'b0, 1'b0, 1'b0, none, acc);
    step(1'b1, $urandom, 5'(1), 2'b10, 1'b0, 1'b1, 1'b0, none, acc);
    idle(1'b0);
    chk("t6_flush_out_valid", 32'(s_out_valid), 32'd0);
    chk("t6_flush_busy", 32'(s_busy), 32'd0);
    chk("t6_flush_in_ready", 32'(s_in_ready), 32'd1);
    // Flush wins over an input transfer that would otherwise be accepted.
    step(1'b1, $urandom, 5'(5), 2'b11, 1'b0, 1'b0, 1'b0, none, acc);
    step(1'b1, $urandom, 5'(6), 2'b00, 1'b0, 1'b1, 1'b0, none, acc);
    chk("t6_flush_in_ready_high", 32'(s_in_ready), 32'd1);
    idle(1'b0);
    chk("t6_flush2_busy", 32'(s_busy), 32'd0);
    chk("t6_flush2_out_valid", 32'(s_out_valid), 32'd0);

    // Random traffic with an asynchronous reset pulse partway through.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        mon_hold = 1'b0;
        rst_n = 1'b1;
      end
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'h8000_0000;
      step(($urandom_range(0, 9) < 7), a, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0), 1'b0, none, acc);
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 30; i++) begin
      idle(1'b1);
      if (sb.size() == 0 && !s_busy) break;
    end
    chk("drain_queue", 32'(sb.size()), 32'd0);
    chk("drain_busy", 32'(s_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Pipelined, handshaked 32-bit shift execution stage for the gate-level ALU datapath.
- Wraps the existing combinational 32-bit truncated shifters: left logical, right logical, right arithmetic and rotate-left.
- Adds operand capture, a registered result and valid/ready flow control so the shift path can sit between the decode/issue stage (upstream) and the writeback mux (downstream).
- Two-stage pipeline: S1 holds the operands, S2 holds the result.

Parameters:
- WIDTH, 32: data width; only 32 is supported.
- SHW, 5: shift-amount width; must equal log2(WIDTH).

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Flush  input  1  synchronous pipeline kill.
- InValid  input  1  upstream request valid.
- InReady  output  1  stage can accept a request.
- In1  input  32  operand to shift.
- In2  input  5  shift amount.
- Op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- OutValid  output  1  result valid.
- OutReady  input  1  downstream accepts.
- Out  output  32  shift result.
- Zero  output  1  Out == 0, registered with Out.
- Busy  output  1  S1 or S2 holds a valid entry.

Behaviour:
- Reset (Rst_n low, asynchronous): S1/S2 valid = 0 and all data registers = 0. Outputs: OutValid 0, Out 0x00000000, Zero 1, Busy 0, InReady 1.
- Handshakes:
  - Input transfer when InValid & InReady at a rising edge.
  - Output transfer when OutValid & OutReady.
- Advance rules:
  - s2_load = S1.valid & (!S2.valid | OutReady).
  - InReady = !S1.valid | s2_load (combinational, no dependency on InValid).
- S1 on input transfer: captures In1, In2, Op and sets valid. Otherwise, if s2_load, clears valid.
- S2 on s2_load: captures shift(S1) and Zero. Otherwise, if output transfer, clears valid.
- Latency and throughput: accept at edge N gives OutValid at edge N+2. One result per cycle is sustained with OutReady held high; no bubbles.
- Backpressure: with OutReady low, at most 2 requests are held and InReady drops to 0. Out, Zero and OutValid stay stable while OutValid & !OutReady.
- Arithmetic:
  - Shift amount 0 passes In1 unchanged for all ops.
  - SLL/SRL zero-fill; SRA sign-fills from In1[31].
  - ROL: result = (In1 << n) | (In1 >> (32-n)).
  - Amount 31 is the maximum; there is no wrap beyond 5 bits.
- Flush: at the next edge clears both valids, overriding any simultaneous input transfer. Data registers keep their values; InReady is 1 the following cycle.
- Simultaneous events: output transfer and s2_load in the same cycle replaces S2 with no gap. Input transfer and s2_load in the same cycle replaces S1.
- Reset mid-operation: all in-flight entries are lost immediately (asynchronous), with no output transfer.

Optional Feature:
- Macro SHIFT_EXEC_CARRY_EN.
- When defined:
  - Adds output port Carry (1 bit), registered in S2 alongside Out.
  - Carry = last bit shifted out:
    - SLL: In1[32-n].
    - SRL/SRA: In1[n-1].
    - ROL: result[0].
  - Carry = 0 when n = 0. Reset value 0.
- When undefined: no Carry port, no extra flops; all other behaviour is identical.

Test Plan:
1. Reset then single request In1=0x80000001, In2=1, Op=SLL, OutReady=1 → OutValid exactly 2 cycles later, Out=0x00000002, Zero=0 (Carry=1 if enabled).
2. SRA In1=0xF0000000, In2=4 → Out=0xFF000000. SRL same operands → 0x0F000000. ROL In1=0x80000001, In2=4 → 0x00000018.
3. Back-to-back 8 requests with OutReady=1 → 8 consecutive OutValid cycles, results in order, InReady never low.
4. OutReady=0, issue 3 requests → first two accepted, InReady=0 on third, Busy=1. Raise OutReady → results drain in order, third accepted on the cycle S2 advances.
5. In1=0x00000001, In2=1, Op=SRL → Out=0, Zero=1 (Carry=1 if enabled). In2=0 with any Op → Out=In1.
6. Flush with both stages full and InValid=1 → next cycle OutValid=0, Busy=0, flushed request not accepted. Separately, Rst_n pulsed low mid-stream → outputs return to reset values asynchronously.
